// File: rtl/reaction_timer_core_pkg.sv
// rtl/reaction_timer_core_pkg.sv - shared encodings and LFSR helper for the reaction timer
package reaction_timer_core_pkg;

  // Game phase as seen by the screen generator
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_REACT = 2'b10,
    ST_DONE  = 2'b11
  } timer_state_e;

  // Outcome of a round; 2'b11 is reserved and never produced
  typedef enum logic [1:0] {
    FAIL_OK    = 2'b00,
    FAIL_EARLY = 2'b01,
    FAIL_SLOW  = 2'b10
  } fail_state_e;

  localparam logic [11:0] LFSR_SEED = 12'hACE;
  localparam logic [3:0]  BCD_NINE  = 4'd9;

  // One step of the 12-bit Fibonacci LFSR, taps 12,6,4,1.
  // Bit 11 always feeds back, so the map is invertible and a nonzero
  // state can never collapse to zero.
  function automatic logic [11:0] lfsr_step(input logic [11:0] cur);
    return {cur[10:0], cur[11] ^ cur[5] ^ cur[3] ^ cur[0]};
  endfunction

endpackage

// File: rtl/reaction_timer_core_bcd.sv
// rtl/reaction_timer_core_bcd.sv - 4-digit BCD up-counter with clear, saturating at 9999
module bcd_counter_4digit
  import reaction_timer_core_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_inc,
  output logic [3:0] o_d3,
  output logic [3:0] o_d2,
  output logic [3:0] o_d1,
  output logic [3:0] o_d0
);

  logic [3:0] r_d3;
  logic [3:0] r_d2;
  logic [3:0] r_d1;
  logic [3:0] r_d0;
  logic       w_full;

  assign w_full = (r_d3 == BCD_NINE) && (r_d2 == BCD_NINE) &&
                  (r_d1 == BCD_NINE) && (r_d0 == BCD_NINE);

  // Units-first decimal increment with carry ripple; holds at 9999
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_d3 <= 4'd0;
      r_d2 <= 4'd0;
      r_d1 <= 4'd0;
      r_d0 <= 4'd0;
    end else if (i_inc && !w_full) begin
      if (r_d0 != BCD_NINE) begin
        r_d0 <= r_d0 + 4'd1;
      end else begin
        r_d0 <= 4'd0;
        if (r_d1 != BCD_NINE) begin
          r_d1 <= r_d1 + 4'd1;
        end else begin
          r_d1 <= 4'd0;
          if (r_d2 != BCD_NINE) begin
            r_d2 <= r_d2 + 4'd1;
          end else begin
            r_d2 <= 4'd0;
            r_d3 <= r_d3 + 4'd1;
          end
        end
      end
    end
  end

  assign o_d3 = r_d3;
  assign o_d2 = r_d2;
  assign o_d1 = r_d1;
  assign o_d0 = r_d0;

endmodule

// File: rtl/reaction_timer_core.sv
// rtl/reaction_timer_core.sv - reaction-timer game sequencer: button edge, LFSR wait, ms timing, result
module reaction_timer_core
  import reaction_timer_core_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int MS_TICKS    = CLK_FREQ / 1000,
  parameter int MIN_WAIT_MS = 2000,
  parameter int RAND_BITS   = 12,
  parameter int TIMEOUT_MS  = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_btn,
  output logic [3:0] o_hex3,
  output logic [3:0] o_hex2,
  output logic [3:0] o_hex1,
  output logic [3:0] o_hex0,
  output logic [1:0] o_timer_state,
  output logic [1:0] o_timer_fail_state,
  output logic       o_stimulus
);

  localparam int PRE_W  = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam int WAIT_W = $clog2(MIN_WAIT_MS + (1 << RAND_BITS)) + 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(MS_TICKS - 1);
  localparam logic [13:0]       MS_LAST   = 14'(TIMEOUT_MS - 1);
  localparam logic [WAIT_W-1:0] WAIT_BASE = WAIT_W'(MIN_WAIT_MS);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  logic              r_btn_q;
  logic              r_armed;
  logic [11:0]       r_lfsr;
  logic [PRE_W-1:0]  r_pre;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [13:0]       r_ms_cnt;
  timer_state_e      r_state;
  fail_state_e       r_fail;
  logic              r_stim;

  logic              w_press;
  logic              w_tick;
  logic              w_wait_done;
  logic              w_timeout;
  logic              w_state_change;
  logic              w_bcd_clr;
  logic              w_bcd_inc;
  logic [WAIT_W-1:0] w_wait_load;
  logic [3:0]        w_d3;
  logic [3:0]        w_d2;
  logic [3:0]        w_d1;
  logic [3:0]        w_d0;

  // r_armed blocks the phantom edge from a button held through reset:
  // btn_q leaves reset at 0, so a press only counts once the button has
  // been seen low at least once.
  assign w_press     = i_btn & ~r_btn_q & r_armed;
  assign w_tick      = (r_pre == PRE_LAST);
  assign w_wait_done = w_tick && (r_wait_cnt <= WAIT_ONE);
  assign w_timeout   = w_tick && (r_ms_cnt == MS_LAST);
  assign w_wait_load = WAIT_BASE + WAIT_W'(r_lfsr[RAND_BITS-1:0]);
  assign w_bcd_clr   = (r_state == ST_IDLE) && w_press;
  assign w_bcd_inc   = (r_state == ST_REACT) && w_tick && !w_press;

  // Flags every edge the FSM will take, so the ms prescaler restarts in phase
  always_comb begin
    w_state_change = 1'b0;
    case (r_state)
      ST_IDLE:  w_state_change = w_press;
      ST_WAIT:  w_state_change = w_press | w_wait_done;
      ST_REACT: w_state_change = w_press | w_timeout;
      ST_DONE:  w_state_change = w_press;
      default:  w_state_change = 1'b0;
    endcase
  end

  // Button history, press arming and the free-running LFSR
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_q <= 1'b0;
      r_armed <= ~i_btn;
      r_lfsr  <= LFSR_SEED;
    end else begin
      r_btn_q <= i_btn;
      r_armed <= r_armed | ~i_btn;
      r_lfsr  <= lfsr_step(r_lfsr);
    end
  end

  // Millisecond prescaler, realigned on every phase change
  always_ff @(posedge i_clk) begin
    if (i_rst || w_state_change || w_tick) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + PRE_W'(1);
    end
  end

  // Game FSM; a press always outranks a simultaneous tick event
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_fail     <= FAIL_OK;
      r_stim     <= 1'b0;
      r_wait_cnt <= '0;
      r_ms_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_press) begin
            r_state    <= ST_WAIT;
            r_wait_cnt <= w_wait_load;
          end
        end
        ST_WAIT: begin
          if (w_press) begin
            r_state <= ST_DONE;
            r_fail  <= FAIL_EARLY;
          end else if (w_wait_done) begin
            r_state  <= ST_REACT;
            r_stim   <= 1'b1;
            r_ms_cnt <= '0;
          end else if (w_tick) begin
            r_wait_cnt <= r_wait_cnt - WAIT_ONE;
          end
        end
        ST_REACT: begin
          if (w_press) begin
            r_state <= ST_DONE;
            r_fail  <= FAIL_OK;
            r_stim  <= 1'b0;
          end else if (w_timeout) begin
            r_state <= ST_DONE;
            r_fail  <= FAIL_SLOW;
            r_stim  <= 1'b0;
          end else if (w_tick) begin
            r_ms_cnt <= r_ms_cnt + 14'd1;
          end
        end
        ST_DONE: begin
          if (w_press) begin
            r_state <= ST_IDLE;
            r_fail  <= FAIL_OK;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_fail  <= FAIL_OK;
          r_stim  <= 1'b0;
        end
      endcase
    end
  end

  bcd_counter_4digit u_bcd (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (w_bcd_clr),
    .i_inc (w_bcd_inc),
    .o_d3  (w_d3),
    .o_d2  (w_d2),
    .o_d1  (w_d1),
    .o_d0  (w_d0)
  );

  assign o_hex3             = w_d3;
  assign o_hex2             = w_d2;
  assign o_hex1             = w_d1;
  assign o_hex0             = w_d0;
  assign o_timer_state      = r_state;
  assign o_timer_fail_state = r_fail;
  assign o_stimulus         = r_stim;

endmodule

// File: tb/tb_reaction_timer_core.sv
// tb/tb_reaction_timer_core.sv - randomized self-checking bench for reaction_timer_core
module tb_reaction_timer_core;

  localparam int CLK_FREQ    = 10_000;
  localparam int MS_TICKS    = 10;
  localparam int MIN_WAIT_MS = 5;
  localparam int RAND_BITS   = 2;
  localparam int TIMEOUT_MS  = 20;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_btn = 1'b0;
  logic [3:0] o_hex3;
  logic [3:0] o_hex2;
  logic [3:0] o_hex1;
  logic [3:0] o_hex0;
  logic [1:0] o_timer_state;
  logic [1:0] o_timer_fail_state;
  logic       o_stimulus;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned edges_since_rst = 0;
  logic [20:0] obs;

  reaction_timer_core #(
    .CLK_FREQ    (CLK_FREQ),
    .MS_TICKS    (MS_TICKS),
    .MIN_WAIT_MS (MIN_WAIT_MS),
    .RAND_BITS   (RAND_BITS),
    .TIMEOUT_MS  (TIMEOUT_MS)
  ) dut (
    .i_clk              (i_clk),
    .i_rst              (i_rst),
    .i_btn              (i_btn),
    .o_hex3             (o_hex3),
    .o_hex2             (o_hex2),
    .o_hex1             (o_hex1),
    .o_hex0             (o_hex0),
    .o_timer_state      (o_timer_state),
    .o_timer_fail_state (o_timer_fail_state),
    .o_stimulus         (o_stimulus)
  );

  always #5 i_clk = ~i_clk;

  // Count clock edges since reset release: the LFSR value is a pure function of it
  always @(posedge i_clk) begin
    if (i_rst) edges_since_rst <= 0;
    else       edges_since_rst <= edges_since_rst + 1;
  end

  assign obs = {o_timer_state, o_timer_fail_state, o_stimulus, o_hex3, o_hex2, o_hex1, o_hex0};

  function automatic logic [11:0] lfsr_at(input int unsigned n);
    logic [11:0] l;
    l = 12'hACE;
    for (int unsigned i = 0; i < n; i++) l = {l[10:0], l[11] ^ l[5] ^ l[3] ^ l[0]};
    return l;
  endfunction

  function automatic logic [20:0] expect_vec(input logic [1:0] st, input logic [1:0] fl,
                                             input logic stim, input int ms);
    logic [3:0] d3, d2, d1, d0;
    d3 = 4'((ms / 1000) % 10);
    d2 = 4'((ms / 100) % 10);
    d1 = 4'((ms / 10) % 10);
    d0 = 4'(ms % 10);
    return {st, fl, stim, d3, d2, d1, d0};
  endfunction

  task automatic tick();
    @(negedge i_clk);
  endtask

  // One-cycle button pulse; the DUT acts on the edge inside this task
  task automatic press();
    i_btn = 1'b1;
    @(negedge i_clk);
    i_btn = 1'b0;
  endtask

  // Start a round from IDLE and run until REACT; returns expected wait and observed dwell
  task automatic go_to_react(output int wait_ms, output int dwell);
    logic [11:0] l;
    l = lfsr_at(edges_since_rst);
    wait_ms = MIN_WAIT_MS + (int'(l) % (1 << RAND_BITS));
    press();
    dwell = 0;
    while (o_timer_state != 2'b10 && dwell < 2000) begin
      tick();
      dwell++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_btn = 1'b1;
    repeat (3) tick();
    i_rst = 1'b0;
    tick();
    n_vec++;
    if (obs !== expect_vec(2'd0, 2'd0, 1'b0, 0)) begin
      n_err++;
      $display("FAIL reset_state: got %h want %h", obs, expect_vec(2'd0, 2'd0, 1'b0, 0));
    end
    repeat (5) tick();
    n_vec++;
    if (o_timer_state !== 2'b00) begin
      n_err++;
      $display("FAIL held_btn_no_press: state %b want 00", o_timer_state);
    end
    i_btn = 1'b0;
    tick();
    n_vec++;
    if (o_timer_state !== 2'b00) begin
      n_err++;
      $display("FAIL btn_release_idle: state %b want 00", o_timer_state);
    end
  endtask

  task automatic test_success();
    int w, d;
    tick();
    go_to_react(w, d);
    n_vec++;
    if (d !== w * MS_TICKS) begin
      n_err++;
      $display("FAIL success_wait_dwell: got %0d want %0d", d, w * MS_TICKS);
    end
    n_vec++;
    if (obs !== expect_vec(2'd2, 2'd0, 1'b1, 0)) begin
      n_err++;
      $display("FAIL react_entry: got %h want %h", obs, expect_vec(2'd2, 2'd0, 1'b1, 0));
    end
    repeat (72) tick();
    press();
    n_vec++;
    if (obs !== expect_vec(2'd3, 2'd0, 1'b0, 7)) begin
      n_err++;
      $display("FAIL success_result: got %h want %h", obs, expect_vec(2'd3, 2'd0, 1'b0, 7));
    end
  endtask

  task automatic test_restart();
    tick();
    press();
    n_vec++;
    if (obs !== expect_vec(2'd0, 2'd0, 1'b0, 7)) begin
      n_err++;
      $display("FAIL restart_idle: got %h want %h", obs, expect_vec(2'd0, 2'd0, 1'b0, 7));
    end
    tick();
    press();
    n_vec++;
    if (obs !== expect_vec(2'd1, 2'd0, 1'b0, 0)) begin
      n_err++;
      $display("FAIL restart_wait: got %h want %h", obs, expect_vec(2'd1, 2'd0, 1'b0, 0));
    end
    tick();
    press();
    tick();
    press();
  endtask

  task automatic test_early();
    logic stim_seen;
    stim_seen = 1'b0;
    tick();
    press();
    repeat (19) begin
      tick();
      if (o_stimulus) stim_seen = 1'b1;
    end
    press();
    n_vec++;
    if (obs !== expect_vec(2'd3, 2'd1, 1'b0, 0) || stim_seen !== 1'b0) begin
      n_err++;
      $display("FAIL early_result: got %h stim_seen %b want %h stim_seen 0",
               obs, stim_seen, expect_vec(2'd3, 2'd1, 1'b0, 0));
    end
    tick();
    press();
  endtask

  task automatic test_slow();
    int w, d, cnt;
    tick();
    go_to_react(w, d);
    cnt = 0;
    while (o_timer_state == 2'b10 && cnt < 500) begin
      tick();
      cnt++;
    end
    n_vec++;
    if (cnt !== TIMEOUT_MS * MS_TICKS) begin
      n_err++;
      $display("FAIL slow_dwell: got %0d want %0d", cnt, TIMEOUT_MS * MS_TICKS);
    end
    n_vec++;
    if (obs !== expect_vec(2'd3, 2'd2, 1'b0, TIMEOUT_MS)) begin
      n_err++;
      $display("FAIL slow_result: got %h want %h", obs, expect_vec(2'd3, 2'd2, 1'b0, TIMEOUT_MS));
    end
    tick();
    press();
  endtask

  // Press lands on the very cycle the wait expires
  task automatic test_wait_expiry();
    logic [11:0] l;
    int w;
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 9)) tick();
      l = lfsr_at(edges_since_rst);
      w = MIN_WAIT_MS + (int'(l) % (1 << RAND_BITS));
      press();
      repeat (w * MS_TICKS - 1) tick();
      n_vec++;
      if (o_timer_state !== 2'b01) begin
        n_err++;
        $display("FAIL pre_expiry_state r%0d: got %b want 01", r, o_timer_state);
      end
      press();
      n_vec++;
      if (obs !== expect_vec(2'd3, 2'd1, 1'b0, 0)) begin
        n_err++;
        $display("FAIL expiry_early r%0d: got %h want %h", r, obs, expect_vec(2'd3, 2'd1, 1'b0, 0));
      end
      tick();
      press();
    end
  endtask

  // Random rounds: the press delay after REACT entry decides the result
  task automatic test_random_rounds();
    int w, d, dly, cnt, ms;
    logic [20:0] exp_v;
    for (int r = 0; r < 10; r++) begin
      repeat ($urandom_range(1, 12)) tick();
      go_to_react(w, d);
      n_vec++;
      if (d !== w * MS_TICKS) begin
        n_err++;
        $display("FAIL rnd_wait_dwell r%0d: got %0d want %0d", r, d, w * MS_TICKS);
      end
      if (r == 0)      dly = TIMEOUT_MS * MS_TICKS;
      else if (r == 1) dly = 1;
      else             dly = int'($urandom_range(1, 230));
      if (dly <= TIMEOUT_MS * MS_TICKS) begin
        repeat (dly - 1) tick();
        press();
        ms = (dly - 1) / MS_TICKS;
        exp_v = expect_vec(2'd3, 2'd0, 1'b0, ms);
      end else begin
        cnt = 0;
        while (o_timer_state == 2'b10 && cnt < 500) begin
          tick();
          cnt++;
        end
        ms = TIMEOUT_MS;
        exp_v = expect_vec(2'd3, 2'd2, 1'b0, ms);
      end
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL rnd_result r%0d dly %0d: got %h want %h", r, dly, obs, exp_v);
      end
      tick();
      press();
      n_vec++;
      if (obs !== expect_vec(2'd0, 2'd0, 1'b0, ms)) begin
        n_err++;
        $display("FAIL rnd_back_idle r%0d: got %h want %h", r, obs, expect_vec(2'd0, 2'd0, 1'b0, ms));
      end
    end
  endtask

  task automatic test_mid_reset();
    int w, d;
    tick();
    go_to_react(w, d);
    repeat (35) tick();
    i_btn = 1'b1;
    i_rst = 1'b1;
    tick();
    n_vec++;
    if (obs !== expect_vec(2'd0, 2'd0, 1'b0, 0)) begin
      n_err++;
      $display("FAIL mid_reset: got %h want %h", obs, expect_vec(2'd0, 2'd0, 1'b0, 0));
    end
    i_rst = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (o_timer_state !== 2'b00) begin
      n_err++;
      $display("FAIL mid_reset_held_btn: state %b want 00", o_timer_state);
    end
    i_btn = 1'b0;
    tick();
    go_to_react(w, d);
    n_vec++;
    if (d !== w * MS_TICKS) begin
      n_err++;
      $display("FAIL post_reset_dwell: got %0d want %0d", d, w * MS_TICKS);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_success();
    test_restart();
    test_early();
    test_slow();
    test_wait_expiry();
    test_random_rounds();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
